// File: rtl/lynxTypes.sv
// rtl/lynxTypes.sv - shared vFPGA I/O switch types for the route-table controller
package lynxTypes;

  localparam int VIO_DEST_BITS = 14;
  localparam int N_REGIONS     = 4;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_BAD_ID  = 2'd2
  } vio_route_st_t;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_PEND   = 2'd1,
    FSM_SETTLE = 2'd2,
    FSM_RESP   = 2'd3
  } vio_route_fsm_t;

endpackage

// File: rtl/vio_pkt_tracker.sv
// rtl/vio_pkt_tracker.sv - per-stream packet-boundary tracker
// A stream is safe to re-route only between packets and with no beat this cycle.
module vio_pkt_tracker (
  input  logic aclk,
  input  logic areset,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic in_pkt,
  output logic safe
);

  logic in_pkt_q;
  logic in_pkt_d;
  logic beat;

  always_comb begin
    beat     = tvalid & tready;
    in_pkt_d = in_pkt_q;
    if (beat) begin
      in_pkt_d = ~tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      in_pkt_q <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
    end
  end

  assign in_pkt = in_pkt_q;
  assign safe   = ~in_pkt_q & ~beat;

endmodule

// File: rtl/vio_route_ctrl.sv
// rtl/vio_route_ctrl.sv - route-table controller committing updates at packet boundaries
// One request at a time: hold the region, wait for a boundary, write, settle, respond.
module vio_route_ctrl
  import lynxTypes::*;
#(
  parameter int                   N_ID           = N_REGIONS,
  parameter int                   DEST_BITS      = VIO_DEST_BITS,
  parameter int                   TIMEOUT_CYCLES = 1024,
  parameter logic [DEST_BITS-1:0] RST_ROUTE      = '0,
  localparam int                  ID_BITS        = (N_ID > 1) ? $clog2(N_ID) : 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ID_BITS-1:0]          cfg_id,
  input  logic [DEST_BITS-1:0]        cfg_route,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [1:0]                  resp_status,
  input  logic [N_ID-1:0]             mon_tvalid,
  input  logic [N_ID-1:0]             mon_tready,
  input  logic [N_ID-1:0]             mon_tlast,
  output logic [N_ID-1:0]             hold,
  output logic [N_ID*DEST_BITS-1:0]   route_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  vio_route_fsm_t       state_q, state_d;
  vio_route_st_t        status_q, status_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [DEST_BITS-1:0] route_q, route_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DEST_BITS-1:0] routes_q [N_ID];
  logic [DEST_BITS-1:0] routes_d [N_ID];

  logic [N_ID-1:0] in_pkt;
  logic [N_ID-1:0] safe;
  logic [N_ID-1:0] id_hit;
  logic            sel_safe;
  logic            bad_id;

  for (genvar g = 0; g < N_ID; g++) begin : g_region
    vio_pkt_tracker u_trk (
      .aclk   (aclk),
      .areset (areset),
      .tvalid (mon_tvalid[g]),
      .tready (mon_tready[g]),
      .tlast  (mon_tlast[g]),
      .in_pkt (in_pkt[g]),
      .safe   (safe[g])
    );
    assign route_out[g*DEST_BITS +: DEST_BITS] = routes_q[g];
  end

  always_comb begin
    id_hit = '0;
    for (int i = 0; i < N_ID; i++) begin
      if (id_q == ID_BITS'(i)) begin
        id_hit[i] = 1'b1;
      end
    end
    sel_safe = |(safe & id_hit) & ~|(in_pkt & id_hit);
    bad_id   = {1'b0, cfg_id} >= (ID_BITS+1)'(N_ID);
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    id_d       = id_q;
    route_d    = route_q;
    cnt_d      = cnt_q;
    routes_d   = routes_q;
    cfg_ready  = 1'b0;
    resp_valid = 1'b0;
    hold       = '0;

    case (state_q)
      FSM_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          id_d    = cfg_id;
          route_d = cfg_route;
          if (bad_id) begin
            status_d = ST_BAD_ID;
            state_d  = FSM_RESP;
          end else begin
            cnt_d   = '0;
            state_d = FSM_PEND;
          end
        end
      end
      FSM_PEND: begin
        hold = id_hit;
        if (sel_safe) begin
          for (int i = 0; i < N_ID; i++) begin
            if (id_hit[i]) begin
              routes_d[i] = route_q;
            end
          end
          status_d = ST_OK;
          state_d  = FSM_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          status_d = ST_TIMEOUT;
          state_d  = FSM_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Extra held cycle lets the switch decode the new route before traffic resumes.
      FSM_SETTLE: begin
        hold    = id_hit;
        state_d = FSM_RESP;
      end
      FSM_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = FSM_IDLE;
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= FSM_IDLE;
      status_q <= ST_OK;
      id_q     <= '0;
      route_q  <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < N_ID; i++) begin
        routes_q[i] <= RST_ROUTE;
      end
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      id_q     <= id_d;
      route_q  <= route_d;
      cnt_q    <= cnt_d;
      routes_q <= routes_d;
    end
  end

  assign resp_status = status_q;

endmodule

// File: tb/tb_vio_route_ctrl.sv
// tb/tb_vio_route_ctrl.sv - self-checking bench for vio_route_ctrl
module tb_vio_route_ctrl;
  import lynxTypes::*;

  localparam int          NI   = 3;
  localparam int          DB   = 14;
  localparam int          TO   = 16;
  localparam logic [13:0] RSTR = 14'h1111;

  logic           aclk = 1'b0;
  logic           areset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_id;
  logic [13:0]    cfg_route;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_status;
  logic [NI-1:0]  mon_tvalid, mon_tready, mon_tlast, hold;
  logic [NI*DB-1:0] route_out;

  vio_route_ctrl #(
    .N_ID(NI), .DEST_BITS(DB), .TIMEOUT_CYCLES(TO), .RST_ROUTE(RSTR)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_id(cfg_id), .cfg_route(cfg_route),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .hold(hold), .route_out(route_out)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0]  id;
    logic [13:0] route;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0] st;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [13:0] exp_route [NI];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] route_of(input int i);
    return route_out[i*DB +: DB];
  endfunction

  function automatic logic [NI-1:0] onehot(input logic [1:0] id);
    logic [NI-1:0] one;
    one = 1;
    return one << id;
  endfunction

  task automatic check_routes(input string tag);
    for (int i = 0; i < NI; i++) chk({tag, "_route"}, route_of(i), exp_route[i]);
  endtask

  task automatic push_exp(input logic [1:0] st, input int lat);
    exp_t e;
    e.st  = st;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Returns at cycle T+1 after the accepting edge.
  task automatic issue(input logic [1:0] id, input logic [13:0] route);
    int k;
    cfg_valid = 1'b1;
    cfg_id    = id;
    cfg_route = route;
    k = 0;
    while (!cfg_ready && k < 100) begin
      tick();
      k++;
    end
    chk("cfg_ready_wait", cfg_ready, 1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_resp(input int start);
    int   lat;
    exp_t e;
    lat = start;
    while (!resp_valid && lat < 64) begin
      tick();
      lat++;
    end
    chk("resp_seen", resp_valid, 1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("resp_status", resp_status, e.st);
      chk("resp_latency", lat, e.lat);
    end
  endtask

  vec_t vt [5];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vt[0] = '{id: 2'd2, route: 14'h0ABC, st: ST_OK,     lat: 3};
    vt[1] = '{id: 2'd0, route: 14'h3FFF, st: ST_OK,     lat: 3};
    vt[2] = '{id: 2'd3, route: 14'h0555, st: ST_BAD_ID, lat: 1};
    vt[3] = '{id: 2'd2, route: 14'h0ABC, st: ST_OK,     lat: 3};
    vt[4] = '{id: 2'd1, route: 14'h0000, st: ST_OK,     lat: 3};

    areset = 1'b1; cfg_valid = 1'b0; cfg_id = '0; cfg_route = '0; resp_ready = 1'b1;
    mon_tvalid = '0; mon_tready = '0; mon_tlast = '0;
    for (int i = 0; i < NI; i++) exp_route[i] = RSTR;
    tick(); tick();
    areset = 1'b0;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_hold", hold, 0);
    check_routes("rst");

    for (int v = 0; v < 5; v++) begin
      push_exp(vt[v].st, vt[v].lat);
      issue(vt[v].id, vt[v].route);
      if (vt[v].st == ST_OK) begin
        chk("hold_pend", hold, onehot(vt[v].id));
        tick();
        chk("route_settle", route_of(vt[v].id), vt[v].route);
        chk("hold_settle", hold, onehot(vt[v].id));
        exp_route[vt[v].id] = vt[v].route;
        wait_resp(2);
      end else begin
        chk("hold_bad", hold, 0);
        wait_resp(1);
      end
      chk("hold_resp", hold, 0);
      check_routes("vec");
      tick();
      chk("cfg_ready_after", cfg_ready, 1);
      chk("resp_valid_after", resp_valid, 0);
    end

    // Mid-packet defer on region 1: request lands after beat 2 of a 5-beat packet.
    mon_tvalid[1] = 1'b1; mon_tready[1] = 1'b1; mon_tlast[1] = 1'b0;
    tick(); tick();
    mon_tvalid[1] = 1'b0;
    push_exp(ST_OK, 6);
    issue(2'd1, 14'h2468);
    chk("defer_hold_t1", hold, 3'b010);
    chk("defer_route_t1", route_of(1), exp_route[1]);
    mon_tvalid[1] = 1'b1;
    tick();
    chk("defer_hold_t2", hold, 3'b010);
    chk("defer_route_t2", route_of(1), exp_route[1]);
    tick();
    mon_tlast[1] = 1'b1;
    chk("defer_route_t3", route_of(1), exp_route[1]);
    tick();
    mon_tlast[1]  = 1'b0;
    mon_tvalid[1] = ~hold[1];
    chk("defer_hold_t4", hold, 3'b010);
    chk("defer_route_t4", route_of(1), exp_route[1]);
    tick();
    chk("defer_route_t5", route_of(1), 14'h2468);
    chk("defer_hold_t5", hold, 3'b010);
    exp_route[1] = 14'h2468;
    wait_resp(5);
    check_routes("defer");
    tick();

    // A beat in the commit-check cycle defers the write by one cycle.
    push_exp(ST_OK, 4);
    issue(2'd2, 14'h0777);
    mon_tvalid[2] = 1'b1; mon_tready[2] = 1'b1; mon_tlast[2] = 1'b1;
    tick();
    mon_tvalid[2] = 1'b0; mon_tlast[2] = 1'b0;
    chk("beatwin_route", route_of(2), exp_route[2]);
    chk("beatwin_hold", hold, 3'b100);
    tick();
    chk("beatwin_commit", route_of(2), 14'h0777);
    exp_route[2] = 14'h0777;
    wait_resp(3);
    tick();

    // Timeout: region 0 stalled mid-packet.
    mon_tvalid[0] = 1'b1; mon_tready[0] = 1'b1; mon_tlast[0] = 1'b0;
    tick();
    mon_tready[0] = 1'b0;
    push_exp(ST_TIMEOUT, TO + 1);
    issue(2'd0, 14'h0F0F);
    wait_resp(1);
    chk("to_route", route_of(0), exp_route[0]);
    chk("to_hold_resp", hold, 0);
    tick();
    chk("to_hold_after", hold, 0);
    chk("to_cfg_ready", cfg_ready, 1);
    mon_tready[0] = 1'b1; mon_tlast[0] = 1'b1;
    tick();
    mon_tvalid[0] = 1'b0; mon_tlast[0] = 1'b0; mon_tready[0] = 1'b0;

    // Response back-pressure with a second request already waiting.
    resp_ready = 1'b0;
    push_exp(ST_OK, 3);
    issue(2'd1, 14'h1357);
    exp_route[1] = 14'h1357;
    wait_resp(1);
    cfg_valid = 1'b1; cfg_id = 2'd2; cfg_route = 14'h0246;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_status", resp_status, ST_OK);
      chk("bp_cfg_ready", cfg_ready, 0);
    end
    chk("bp_route2", route_of(2), exp_route[2]);
    resp_ready = 1'b1;
    tick();
    chk("bp_cfg_ready_r1", cfg_ready, 1);
    chk("bp_resp_valid_r1", resp_valid, 0);
    push_exp(ST_OK, 3);
    tick();
    cfg_valid = 1'b0;
    chk("bp_second_hold", hold, 3'b100);
    exp_route[2] = 14'h0246;
    wait_resp(1);
    check_routes("bp");
    tick();

    // Reset while pending: response dropped, tracker state cleared.
    mon_tvalid[2] = 1'b1; mon_tready[2] = 1'b1; mon_tlast[2] = 1'b0;
    tick();
    mon_tvalid[2] = 1'b0;
    issue(2'd2, 14'h3333);
    tick(); tick();
    chk("rp_hold_pend", hold, 3'b100);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    for (int i = 0; i < NI; i++) exp_route[i] = RSTR;
    chk("rp_hold", hold, 0);
    chk("rp_resp_valid", resp_valid, 0);
    chk("rp_cfg_ready", cfg_ready, 1);
    chk("rp_status", resp_status, 0);
    check_routes("rp");
    push_exp(ST_OK, 3);
    issue(2'd2, 14'h3333);
    exp_route[2] = 14'h3333;
    wait_resp(1);
    check_routes("rp_fresh");
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
